// File: rtl/serdes_pkg.sv
// Shared SerDes definitions: state encoding for the bit serializer and the
// receive-side deserializer, default word width, and a counter-width helper.
package serdes_pkg;

    // Default parallel word width of the SerDes datapath
    localparam int unsigned SERDES_DATA_WIDTH = 8;

    // IDLE: shift register empty; SHIFT: a word is being emitted bit by bit
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Width of a counter indexing the bits of a word (at least one bit)
    function automatic int unsigned ser_cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fifo_bit_serializer.sv
// Parallel-in, serial-out stage feeding the bit-wide transmit FIFO.
// Words arrive over valid/ready, are emitted one bit per cycle on the FIFO
// write port, and stall while the FIFO reports full. A one-entry holding
// register lets the next word start on the cycle after the last bit.
//
// Ports:
//   i_Clk       write-domain clock, all state on rising edge
//   i_Rst_n     asynchronous active-low reset
//   i_Data      parallel word
//   i_Valid     i_Data valid
//   o_Ready     word accepted on an edge where i_Valid & o_Ready
//   i_full      FIFO full flag
//   o_W_en      FIFO write enable (combinational)
//   o_Data_Out  serial bit to FIFO write data
//   o_Busy      word in shift register or holding register
module fifo_bit_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SERDES_DATA_WIDTH,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [DATA_WIDTH-1:0] i_Data,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_full,
    output logic                  o_W_en,
    output logic                  o_Data_Out,
    output logic                  o_Busy
);

    localparam int unsigned      CNT_W    = ser_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    ser_state_t            state_q;
    ser_state_t            state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_adv;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ready_en_q;
    logic                  out_bit;
    logic                  accept;
    logic                  wr;
    logic                  last_wr;

    // Output-end bit and the shift register advanced by one position
    always_comb begin
        out_bit   = 1'b0;
        shift_adv = '0;
        if (LSB_FIRST) begin
            out_bit   = shift_q[0];
            shift_adv = {1'b0, shift_q[DATA_WIDTH-1:1]};
        end else begin
            out_bit   = shift_q[DATA_WIDTH-1];
            shift_adv = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Handshake and write-edge qualifiers
    always_comb begin
        accept  = i_Valid & o_Ready;
        wr      = o_W_en;
        last_wr = wr & (cnt_q == LAST_CNT);
    end

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SHIFT only when the last bit goes out with no
    // successor word available from hold or from the input
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_wr && !hold_valid_q && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; o_Ready stays low until the first edge after reset release
    always_comb begin
        o_W_en     = 1'b0;
        o_Data_Out = 1'b0;
        o_Busy     = 1'b0;
        o_Ready    = 1'b0;
        if (state_q == SHIFT) begin
            o_W_en     = !i_full;
            o_Data_Out = out_bit;
        end
        o_Busy  = (state_q == SHIFT) | hold_valid_q;
        o_Ready = ready_en_q & !hold_valid_q;
    end

    // Ready enable: set on the first rising edge after reset release
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Shift register, bit counter and holding register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= i_Data;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (last_wr) begin
                        // Successor priority: held word, then same-edge input
                        cnt_q <= '0;
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                        end else if (accept) begin
                            shift_q <= i_Data;
                        end else begin
                            shift_q <= '0;
                        end
                    end else begin
                        if (wr) begin
                            shift_q <= shift_adv;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                        if (accept) begin
                            hold_q       <= i_Data;
                            hold_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// Self-checking bench for fifo_bit_serializer: an LSB-first and an MSB-first
// instance share all inputs and are compared every cycle against a queue
// model of the bits still owed to the FIFO.
module tb_fifo_bit_serializer;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          full;
    logic          rdy_l, wen_l, dout_l, busy_l;
    logic          rdy_m, wen_m, dout_m, busy_m;

    int            checks       = 0;
    int            failures     = 0;
    int            exp_writes   = 0;
    int            obs_writes   = 0;
    int            phase_writes = 0;
    logic [15:0]   cap_l        = '0;
    logic [15:0]   cap_m        = '0;
    bit            q_l[$];
    bit            q_m[$];
    bit            ready_en     = 1'b0;

    always #5 clk = ~clk;

    fifo_bit_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) u_dut_lsb (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data), .i_Valid(valid),
        .o_Ready(rdy_l), .i_full(full), .o_W_en(wen_l),
        .o_Data_Out(dout_l), .o_Busy(busy_l)
    );

    fifo_bit_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) u_dut_msb (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(data), .i_Valid(valid),
        .o_Ready(rdy_m), .i_full(full), .o_W_en(wen_m),
        .o_Data_Out(dout_m), .o_Busy(busy_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare outputs, advance model at posedge
    task automatic step(input logic rst, input logic v, input logic [DW-1:0] d,
                        input logic f, output bit acc);
        int words;
        bit e_busy, e_wen, e_rdy, e_dl, e_dm;
        rst_n = rst;
        valid = v;
        data  = d;
        full  = f;
        #1;
        if (!rst) begin
            q_l.delete();
            q_m.delete();
            ready_en = 1'b0;
        end
        words  = (q_l.size() + DW - 1) / DW;
        e_busy = (q_l.size() != 0);
        e_wen  = e_busy && !f;
        e_rdy  = ready_en && (words < 2);
        e_dl   = e_busy ? q_l[0] : 1'b0;
        e_dm   = e_busy ? q_m[0] : 1'b0;
        check("ready_lsb", 32'(rdy_l),  32'(e_rdy));
        check("wen_lsb",   32'(wen_l),  32'(e_wen));
        check("dout_lsb",  32'(dout_l), 32'(e_dl));
        check("busy_lsb",  32'(busy_l), 32'(e_busy));
        check("ready_msb", 32'(rdy_m),  32'(e_rdy));
        check("wen_msb",   32'(wen_m),  32'(e_wen));
        check("dout_msb",  32'(dout_m), 32'(e_dm));
        check("busy_msb",  32'(busy_m), 32'(e_busy));
        if (wen_l === 1'b1) begin
            obs_writes++;
            phase_writes++;
            cap_l = {dout_l, cap_l[15:1]};
        end
        if (wen_m === 1'b1) begin
            cap_m = {cap_m[14:0], dout_m};
        end
        acc = rst && v && e_rdy;
        @(posedge clk);
        if (rst) begin
            if (e_wen) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
                exp_writes++;
            end
            if (acc) begin
                for (int i = 0; i < DW; i++) begin
                    q_l.push_back(d[i]);
                    q_m.push_back(d[DW-1-i]);
                end
            end
            ready_en = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0, acc);
    endtask

    // Hold i_Valid with the word until the model accepts it (bounded)
    task automatic send(input logic [DW-1:0] w);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, 1'b1, w, 1'b0, acc);
            n++;
        end
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic new_phase();
        phase_writes = 0;
        cap_l        = '0;
        cap_m        = '0;
    endtask

    initial begin
        bit acc;
        rst_n = 1'b1;
        valid = 1'b0;
        data  = '0;
        full  = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset held with i_Valid high: nothing accepted
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0, acc);

        // Single word LSB/MSB order
        new_phase();
        send(8'hA5);
        idle(10);
        check("a5_writes", 32'(phase_writes), 32'd8);
        check("a5_bits_lsb", 32'(cap_l[15:8]), 32'h A5);
        check("a5_bits_msb", 32'(cap_m[7:0]), 32'h A5);

        // Back-to-back words through the holding register
        new_phase();
        send(8'h0F);
        send(8'hF0);
        idle(18);
        check("b2b_writes", 32'(phase_writes), 32'd16);
        check("b2b_bits_lsb", 32'(cap_l), 32'h F00F);
        check("b2b_bits_msb", 32'(cap_m), 32'h 0FF0);

        // FIFO full for 3 cycles after bit 2
        new_phase();
        send(8'h3C);
        idle(3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1, acc);
        idle(8);
        check("full_writes", 32'(phase_writes), 32'd8);
        check("full_bits_lsb", 32'(cap_l[15:8]), 32'h 3C);

        // Reset after 4 writes discards the partial word
        new_phase();
        send(8'hFF);
        idle(4);
        step(1'b0, 1'b1, 8'h5A, 1'b0, acc);
        step(1'b0, 1'b1, 8'h5A, 1'b0, acc);
        idle(4);
        check("rst_mid_writes", 32'(phase_writes), 32'd4);

        // MSB-first ordering example
        new_phase();
        send(8'hB0);
        idle(10);
        check("b0_bits_msb", 32'(cap_m[7:0]), 32'h B0);
        check("b0_bits_lsb", 32'(cap_l[15:8]), 32'h B0);

        // Randomized traffic with full stalls and occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)),
                 DW'($urandom), ($urandom_range(0, 3) == 0), acc);
        end
        idle(40);
        check("drained", 32'(q_l.size()), 32'd0);
        check("total_writes", 32'(obs_writes), 32'(exp_writes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_bit_serializer.md
# fifo_bit_serializer

Parallel-in, serial-out stage directly upstream of the bit-wide FIFO memory in the SerDes transmit path. Accepts DATA_WIDTH-bit words over a valid/ready handshake and emits them one bit per cycle onto the FIFO write port, stalling on the FIFO full flag. A one-entry holding register allows gap-free back-to-back words.

## Interface
- DATA_WIDTH, 8, word width in bits; legal range ≥2
- LSB_FIRST, 1, 1 = bit 0 serialized first, 0 = bit DATA_WIDTH-1 first
- i_Clk  input  1  write-domain clock; all state on rising edge
- i_Rst_n  input  1  reset, asynchronous assert, active-low
- i_Data  input  DATA_WIDTH  parallel word
- i_Valid  input  1  i_Data valid
- o_Ready  output  1  word accepted on an edge where i_Valid & o_Ready
- i_full  input  1  FIFO full flag (write domain)
- o_W_en  output  1  FIFO write enable
- o_Data_Out  output  1  serial bit to FIFO write data
- o_Busy  output  1  word in shift register or holding register

## Operation
- Storage: shift register (DATA_WIDTH), bit counter ($clog2(DATA_WIDTH) bits), holding register + hold_valid, state.
- States: IDLE (shift register empty), SHIFT (word in flight).
- o_Ready = !hold_valid (0 while i_Rst_n low).
- o_Data_Out = shift[0] if LSB_FIRST else shift[DATA_WIDTH-1]; 0 in IDLE.
- o_W_en = (state==SHIFT) & !i_full, combinational.
- Bit written on any edge with o_W_en=1: shift register moves one position toward the output end, counter increments.
- Last bit = write edge with counter==DATA_WIDTH-1. On that edge, next-word source priority: holding register (hold_valid clears) > same-edge accepted input (bypasses hold) > none (→IDLE). Counter returns to 0.
- IDLE + accept: word loads directly into shift register, state→SHIFT; holding register untouched.
- SHIFT + accept, not last-bit edge: word goes to holding register, hold_valid=1.
- i_full high: shift register, counter and o_Data_Out frozen; no writes lost or duplicated.
- o_Busy = (state==SHIFT) | hold_valid.
- i_Valid with o_Ready=0: ignored; upstream holds the word.

## Timing
- Reset values (async, immediate): state IDLE, counter 0, shift 0, hold_valid 0; o_W_en 0, o_Data_Out 0, o_Busy 0, o_Ready 0 during reset, 1 from first cycle after release.
- Reset mid-word: partial word and held word discarded; no further writes.
- Latency: word accepted at edge N (IDLE) → first bit with o_W_en=1 in cycle N+1 (if !i_full).
- Throughput: i_Valid held, i_full low → exactly one write per cycle, no gap between words.
- A word accepted into hold stays until the current word's last bit is written; o_Ready low meanwhile.

## Structure
- serdes_pkg: state enum typedef (IDLE, SHIFT) and default DATA_WIDTH constant; shared with the receive-side deserializer.
- Single module; no sub-module (shift register and counter inline).

## Test plan
- DATA_WIDTH=8, LSB_FIRST=1, send 0xA5, i_full=0 → o_Data_Out 1,0,1,0,0,1,0,1 on 8 consecutive o_W_en cycles, then o_Busy=0.
- Back-to-back 0x0F then 0xF0, i_Valid held → 16 consecutive o_W_en cycles, bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; o_Ready low while 0xF0 in hold.
- 0x3C, i_full high 3 cycles after bit 2 written → o_W_en 0 for 3 cycles, o_Data_Out holds bit 3 (=1); exactly 8 writes total, pattern 0,0,1,1,1,1,0,0.
- 0xFF, i_Rst_n low after 4 writes → o_W_en/o_Busy 0 same cycle; after release o_Ready=1, no residual writes.
- LSB_FIRST=0, send 0xB0 → bits 1,0,1,1,0,0,0,0.
- i_Valid high during reset and while o_Ready=0 → no acceptance; write count unchanged.
